// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Turns the PS/2 set-2 scancode byte stream into level-held movement flags
//   and keeps a sticky game-over status for the register file.
// Ports
//   clock           in   system clock, rising edge
//   ctrl_reset      in   asynchronous active-high reset
//   ps2_key_data    in   [7:0] scancode byte, valid while ps2_key_pressed=1
//   ps2_key_pressed in   one-cycle strobe: new byte on ps2_key_data
//   game_over       in   one-cycle strobe: game has ended
//   move_left       out  A (1C) or left arrow (E0 6B) held
//   move_right      out  D (23) or right arrow (E0 74) held
//   game_status     out  1 from game_over until a space (29) make
module ps2_key_tracker #(
  parameter int PREFIX_TIMEOUT = 1_000_000,
  parameter int HOLD_TIMEOUT   = 50_000_000,
  parameter int CNT_W          = 26
) (
  input  logic       clock,
  input  logic       ctrl_reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  input  logic       game_over,
  output logic       move_left,
  output logic       move_right,
  output logic       game_status
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PREFIX_LAST = CNT_W'(PREFIX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX    = CNT_W'(HOLD_TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] idle_cnt;
  logic             h_a, h_la, h_d, h_ra;
  logic             prefix_expire;
  logic             hold_expire;
  logic             space_make;

  // Outputs are ORs of hold flops; no combinational path from inputs.
  assign move_left  = h_a | h_la;
  assign move_right = h_d | h_ra;

  // Timeout events fire on the edge where the counter reaches its limit.
  always_comb begin
    prefix_expire = 1'b0;
    hold_expire   = 1'b0;
    space_make    = 1'b0;
    if (ps2_key_pressed) begin
      space_make = (state == IDLE) && (ps2_key_data == 8'h29);
    end else begin
      prefix_expire = (idle_cnt == PREFIX_LAST);
      hold_expire   = (idle_cnt == HOLD_LAST);
    end
  end

  // Idle counter: cleared by any byte, saturates at the hold timeout.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      idle_cnt <= '0;
    end else if (ps2_key_pressed) begin
      idle_cnt <= '0;
    end else if (idle_cnt != HOLD_MAX) begin
      idle_cnt <= idle_cnt + CNT_ONE;
    end else begin
      idle_cnt <= idle_cnt;
    end
  end

  // Scancode FSM and hold bits.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state <= IDLE;
      h_a   <= 1'b0;
      h_la  <= 1'b0;
      h_d   <= 1'b0;
      h_ra  <= 1'b0;
    end else if (ps2_key_pressed) begin
      case (state)
        IDLE: begin
          case (ps2_key_data)
            8'hE0:   state <= EXT;
            8'hF0:   state <= BRK;
            8'h1C:   h_a   <= 1'b1;
            8'h23:   h_d   <= 1'b1;
            default: state <= IDLE;  // space, E1 and unknown bytes
          endcase
        end
        EXT: begin
          case (ps2_key_data)
            8'hF0:   state <= EXT_BRK;
            8'hE0:   state <= EXT;   // repeated prefix keeps waiting
            8'h6B: begin h_la <= 1'b1; state <= IDLE; end
            8'h74: begin h_ra <= 1'b1; state <= IDLE; end
            default: state <= IDLE;
          endcase
        end
        BRK: begin
          // A prefix byte here is malformed; falls into default.
          case (ps2_key_data)
            8'h1C:   h_a <= 1'b0;
            8'h23:   h_d <= 1'b0;
            default: h_a <= h_a;
          endcase
          state <= IDLE;
        end
        EXT_BRK: begin
          case (ps2_key_data)
            8'h6B:   h_la <= 1'b0;
            8'h74:   h_ra <= 1'b0;
            default: h_la <= h_la;
          endcase
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end else begin
      // Abandon a dangling prefix; stuck-key guard releases everything.
      if (prefix_expire) begin
        state <= IDLE;
      end
      if (hold_expire) begin
        h_a  <= 1'b0;
        h_la <= 1'b0;
        h_d  <= 1'b0;
        h_ra <= 1'b0;
      end
    end
  end

  // Sticky game status; a same-cycle game_over beats the space clear.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      game_status <= 1'b0;
    end else if (game_over) begin
      game_status <= 1'b1;
    end else if (space_make) begin
      game_status <= 1'b0;
    end else begin
      game_status <= game_status;
    end
  end

endmodule
